// File: rtl/filtro_biquad_adc.sv
// -----------------------------------------------------------------------------
// filtro_biquad_adc
// Second-order IIR low-pass (biquad, direct form I) placed right after the ADC
// capture stage. A single multiplier is shared across the five taps, one tap
// per clock, so each sample costs five MAC cycles plus one output cycle.
//
// Optional feature macro: FILTRO_SAT_EN
//   defined   : the rounded result saturates to the signed cant_bits range
//   undefined : the rounded result wraps (keeps its low cant_bits bits)
//
// Ports
//   clk        in   1          system clock
//   rst        in   1          synchronous, active-high reset
//   din        in   cant_bits  signed ADC sample (sign-extended 12-bit word)
//   din_valid  in   1          one-cycle strobe qualifying din
//   dout       out  cant_bits  signed filtered sample, held between updates
//   dout_valid out  1          one-cycle pulse when dout updates
//   busy       out  1          high while a sample is being processed
//   overrun    out  1          one-cycle pulse when a strobe is dropped
// -----------------------------------------------------------------------------
module filtro_biquad_adc #(
  parameter int                   cant_bits = 16,
  parameter int                   CW        = 16,
  parameter int                   FRAC      = 14,
  parameter logic signed [CW-1:0] B0        = 16'sd1024,
  parameter logic signed [CW-1:0] B1        = 16'sd2048,
  parameter logic signed [CW-1:0] B2        = 16'sd1024,
  parameter logic signed [CW-1:0] A1        = -16'sd18022,
  parameter logic signed [CW-1:0] A2        = 16'sd6144
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [cant_bits-1:0] din,
  input  logic                        din_valid,
  output logic signed [cant_bits-1:0] dout,
  output logic                        dout_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int PW = CW + cant_bits;   // product width
  localparam int AW = PW + 3;           // accumulator width, headroom for 5 sums

  // Rounding constant: one half LSB of the output scale (round half up).
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                      state;
  logic [2:0]                  idx;
  logic signed [cant_bits-1:0] x0, x1, x2, y1, y2;
  logic signed [AW-1:0]        acc;
  logic                        out_pend;

  logic signed [CW-1:0]        coef;
  logic signed [cant_bits-1:0] opnd;
  logic                        sub;
  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        prod_ext;
  logic signed [AW-1:0]        rnd_sum;
  logic signed [cant_bits-1:0] y_red;

  // Tap selection for the shared multiplier; feedback taps are subtracted.
  always_comb begin
    coef = {CW{1'b0}};
    opnd = {cant_bits{1'b0}};
    sub  = 1'b0;
    case (idx)
      3'd0:    begin coef = B0; opnd = x0; sub = 1'b0; end
      3'd1:    begin coef = B1; opnd = x1; sub = 1'b0; end
      3'd2:    begin coef = B2; opnd = x2; sub = 1'b0; end
      3'd3:    begin coef = A1; opnd = y1; sub = 1'b1; end
      3'd4:    begin coef = A2; opnd = y2; sub = 1'b1; end
      default: begin coef = {CW{1'b0}}; opnd = {cant_bits{1'b0}}; sub = 1'b0; end
    endcase
  end

  assign prod     = PW'(coef) * PW'(opnd);
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign rnd_sum  = acc + RND;

`ifdef FILTRO_SAT_EN
  localparam logic signed [AW-1:0] YMAX = {{(AW-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};
  logic signed [AW-1:0] r_full;
  assign r_full = rnd_sum >>> FRAC;

  // Clamp the rounded result into the output range.
  always_comb begin
    y_red = {cant_bits{1'b0}};
    if (r_full > YMAX) begin
      y_red = YMAX[cant_bits-1:0];
    end else if (r_full < YMIN) begin
      y_red = YMIN[cant_bits-1:0];
    end else begin
      y_red = r_full[cant_bits-1:0];
    end
  end
`else
  // Keep only the low bits of the rounded result (two's-complement wrap).
  always_comb begin
    y_red = cant_bits'(rnd_sum >>> FRAC);
  end
`endif

  // Control FSM, MAC datapath, history and registered outputs.
  // dout is loaded one cycle after OUT from y1, which already holds the new y.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      acc        <= {AW{1'b0}};
      x0         <= {cant_bits{1'b0}};
      x1         <= {cant_bits{1'b0}};
      x2         <= {cant_bits{1'b0}};
      y1         <= {cant_bits{1'b0}};
      y2         <= {cant_bits{1'b0}};
      out_pend   <= 1'b0;
      dout       <= {cant_bits{1'b0}};
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= din_valid && (state != IDLE);
      busy       <= (state != IDLE);
      dout_valid <= out_pend;
      out_pend   <= 1'b0;
      if (out_pend) begin
        dout <= y1;
      end else begin
        dout <= dout;
      end
      case (state)
        IDLE: begin
          if (din_valid) begin
            x0    <= din;
            acc   <= {AW{1'b0}};
            idx   <= 3'd0;
            state <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          if (sub) begin
            acc <= acc - prod_ext;
          end else begin
            acc <= acc + prod_ext;
          end
          if (idx == 3'd4) begin
            state <= OUT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        OUT: begin
          x2       <= x1;
          x1       <= x0;
          y2       <= y1;
          y1       <= y_red;
          out_pend <= 1'b1;
          idx      <= 3'd0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_biquad_adc.sv
module tb_filtro_biquad_adc;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] din;
  logic din_valid;

  // Instance 0: default taps, 1: FIR 0.25 x3, 2: y=x+0.5*y1, 3: unity x3
  logic signed [15:0] dout_a [4];
  logic dv_a [4];
  logic busy_a [4];
  logic ovr_a [4];

  always #5 clk = ~clk;

  filtro_biquad_adc dut_def (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_a[0]), .dout_valid(dv_a[0]), .busy(busy_a[0]), .overrun(ovr_a[0]));

  filtro_biquad_adc #(.B0(16'sd4096), .B1(16'sd4096), .B2(16'sd4096), .A1(16'sd0), .A2(16'sd0)) dut_fir (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_a[1]), .dout_valid(dv_a[1]), .busy(busy_a[1]), .overrun(ovr_a[1]));

  filtro_biquad_adc #(.B0(16'sd16384), .B1(16'sd0), .B2(16'sd0), .A1(-16'sd8192), .A2(16'sd0)) dut_fb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_a[2]), .dout_valid(dv_a[2]), .busy(busy_a[2]), .overrun(ovr_a[2]));

  filtro_biquad_adc #(.B0(16'sd16384), .B1(16'sd16384), .B2(16'sd16384), .A1(16'sd0), .A2(16'sd0)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout_a[3]), .dout_valid(dv_a[3]), .busy(busy_a[3]), .overrun(ovr_a[3]));

  // Reference coefficients for the four instances
  longint cb0 [4] = '{1024, 4096, 16384, 16384};
  longint cb1 [4] = '{2048, 4096, 0, 16384};
  longint cb2 [4] = '{1024, 4096, 0, 16384};
  longint ca1 [4] = '{-18022, 0, -8192, 0};
  longint ca2 [4] = '{6144, 0, 0, 0};

  // Reference filter history (x[n-1], x[n-2], y[n-1], y[n-2])
  longint mx1 [4];
  longint mx2 [4];
  longint my1 [4];
  longint my2 [4];

`ifdef FILTRO_SAT_EN
  localparam longint SAT2 = 32767;
`else
  localparam longint SAT2 = -5536;
`endif

  int npass = 0;
  int nchk  = 0;

  function automatic longint reduce(input longint r);
    longint w;
`ifdef FILTRO_SAT_EN
    if (r > 32767) w = 32767;
    else if (r < -32768) w = -32768;
    else w = r;
`else
    w = r % 65536;
    if (w < 0) w = w + 65536;
    if (w > 32767) w = w - 65536;
`endif
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
    end
  endtask

  // y = round_half_up(difference equation / 2^14), then reduced to 16 bits
  task automatic model_accept(input longint x);
    for (int k = 0; k < 4; k++) begin
      longint s;
      longint r;
      longint y;
      s = cb0[k] * x + cb1[k] * mx1[k] + cb2[k] * mx2[k] - ca1[k] * my1[k] - ca2[k] * my2[k];
      r = s + 8192;
      r = (r >= 0) ? (r / 16384) : -((-r + 16383) / 16384);
      y = reduce(r);
      mx2[k] = mx1[k]; mx1[k] = x;
      my2[k] = my1[k]; my1[k] = y;
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted sample: checks busy/valid timing and output against the model
  task automatic send(input longint x);
    din = 16'(x);
    din_valid = 1'b1;
    model_accept(x);
    tick();
    din_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("busy_e%0d", i), longint'(busy_a[0]), 1);
      chk($sformatf("dv_early_e%0d", i), longint'(dv_a[1]), 0);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dout%0d", k), longint'(dout_a[k]), my1[k]);
      chk($sformatf("dv%0d", k), longint'(dv_a[k]), 1);
    end
    chk("busy_e7", longint'(busy_a[0]), 0);
    tick();
    chk("dv_pulse", longint'(dv_a[0]), 0);
    chk("dout_hold", longint'(dout_a[2]), my1[2]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nvalid;
    rst = 1'b1;
    din = 16'sd0;
    din_valid = 1'b0;
    model_reset();

    // Reset state
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rst_dout", longint'(dout_a[k]), 0);
      chk("rst_dv", longint'(dv_a[k]), 0);
      chk("rst_busy", longint'(busy_a[k]), 0);
      chk("rst_ovr", longint'(ovr_a[k]), 0);
    end
    rst = 1'b0;
    send(0);
    chk("t1_zero", longint'(dout_a[0]), 0);

    // FIR path: 0.25 x3
    do_reset();
    send(400); chk("t2_a", longint'(dout_a[1]), 100);
    send(400); chk("t2_b", longint'(dout_a[1]), 200);
    send(400); chk("t2_c", longint'(dout_a[1]), 300);

    // Feedback path
    do_reset();
    send(1000); chk("t3_a", longint'(dout_a[2]), 1000);
    send(1000); chk("t3_b", longint'(dout_a[2]), 1500);
    send(1000); chk("t3_c", longint'(dout_a[2]), 1750);
    send(1000); chk("t3_d", longint'(dout_a[2]), 1875);

    // Saturation / wrap
    do_reset();
    send(30000); chk("t4_a", longint'(dout_a[3]), 30000);
    send(30000); chk("t4_b", longint'(dout_a[3]), SAT2);

    // Overrun: second strobe three cycles after the first is dropped
    do_reset();
    din = 16'sd1234;
    din_valid = 1'b1;
    model_accept(1234);
    tick();
    din_valid = 1'b0;
    tick(); chk("t5_ovr_e1", longint'(ovr_a[0]), 0);
    tick(); chk("t5_ovr_e2", longint'(ovr_a[0]), 0);
    din = 16'sd5000;
    din_valid = 1'b1;
    tick(); chk("t5_ovr_e3", longint'(ovr_a[0]), 1);
    din_valid = 1'b0;
    tick(); chk("t5_ovr_e4", longint'(ovr_a[0]), 0);
    nvalid = 0;
    for (int i = 5; i <= 14; i++) begin
      tick();
      if (dv_a[1]) nvalid++;
      if (i == 7) begin
        for (int k = 0; k < 4; k++) chk($sformatf("t5_dout%0d", k), longint'(dout_a[k]), my1[k]);
        chk("t5_fir", longint'(dout_a[1]), 309);
      end
    end
    chk("t5_nvalid", nvalid, 1);

    // Reset in the middle of MAC
    din = 16'sd777;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("t6_busy", longint'(busy_a[0]), 0);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dv_a[0]) nvalid++;
    end
    chk("t6_nvalid", nvalid, 0);
    send(400);
    chk("t6_fir", longint'(dout_a[1]), 100);

    // Randomized 12-bit samples against the model
    for (int n = 0; n < 24; n++) begin
      int gap;
      longint v;
      v = longint'($urandom_range(4095)) - 2048;
      send(v);
      gap = int'($urandom_range(3));
      for (int g = 0; g < gap; g++) tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
